mc_fetch_unit: RTL and testbench

//  Upstream fetch stage of the multi-cycle CPU: owns the PC and the instruction register (IR).

---
 rtl/mc_cpu_pkg.sv | 26 ++
 rtl/mc_fetch_unit_if.sv | 13 +
 rtl/mc_next_pc.sv | 26 ++
 rtl/mc_fetch_unit.sv | 120 ++++++++++++
 tb/tb_mc_fetch_unit.sv | 288 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mc_cpu_pkg.sv
// Shared definitions for the multi-cycle CPU: opcodes, PC-source encodings,
// the HALT instruction word and the fetch FSM state type.
package mc_cpu_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [5:0] OP_J    = 6'b111000;
    localparam logic [5:0] OP_JR   = 6'b111001;
    localparam logic [5:0] OP_JAL  = 6'b111010;
    localparam logic [5:0] OP_BEQ  = 6'b110100;
    localparam logic [5:0] OP_HALT = 6'b111111;

    localparam logic [1:0] PCSRC_PLUS4  = 2'b00;
    localparam logic [1:0] PCSRC_BRANCH = 2'b01;
    localparam logic [1:0] PCSRC_JR     = 2'b10;
    localparam logic [1:0] PCSRC_JUMP   = 2'b11;

    localparam logic [31:0] HALT_INSN = 32'hFC00_0000;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StReq  = 2'b01,
        StDone = 2'b10
    } fetch_state_e;

endpackage

// File: rtl/mc_fetch_unit_if.sv
// Instruction-memory request/acknowledge bus between the fetch unit and imem.
interface mc_fetch_unit_if;
    import mc_cpu_pkg::*;

    logic            req;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] rdata;
    logic            ack;

    modport master (output req, output addr, input rdata, input ack);
    modport slave  (input req, input addr, output rdata, output ack);

endinterface

// File: rtl/mc_next_pc.sv
// Combinational next-PC selector: sequential, PC-relative branch, register
// indirect (jr) and pseudo-direct jump targets. All arithmetic wraps mod 2^32.
module mc_next_pc
    import mc_cpu_pkg::*;
(
    input  logic [1:0]  pc_src,
    input  logic [31:0] pc_plus4,
    input  logic [31:0] ext_imm,
    input  logic [31:0] rs_data,
    input  logic [25:0] instr_index,
    output logic [31:0] next_pc
);

    always_comb begin
        next_pc = pc_plus4;
        case (pc_src)
            PCSRC_PLUS4:  next_pc = pc_plus4;
            // Shifting the full word equals {ext_imm[29:0],2'b00}.
            PCSRC_BRANCH: next_pc = pc_plus4 + (ext_imm << 2);
            PCSRC_JR:     next_pc = rs_data & 32'hFFFF_FFFC;
            PCSRC_JUMP:   next_pc = {pc_plus4[31:28], instr_index, 2'b00};
            default:      next_pc = pc_plus4;
        endcase
    end

endmodule

// File: rtl/mc_fetch_unit.sv
// Fetch stage of the multi-cycle CPU: owns PC and IR, fetches over a req/ack
// bus, applies next-PC selection, and halts on HALT opcode or fetch timeout.
module mc_fetch_unit
    import mc_cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned TIMEOUT  = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   pc_wre,
    input  logic                   ir_wre,
    input  logic [1:0]             pc_src,
    input  logic [31:0]            ext_imm,
    input  logic [31:0]            rs_data,
    mc_fetch_unit_if.master        imem,
    output logic [31:0]            pc,
    output logic [31:0]            pc_plus4,
    output logic [31:0]            ir,
    output logic [5:0]             opcode,
    output logic [4:0]             rs,
    output logic [4:0]             rt,
    output logic [4:0]             rd,
    output logic [4:0]             sa,
    output logic [15:0]            imm16,
    output logic                   fetch_busy,
    output logic                   ir_valid,
    output logic                   halted,
    output logic                   fetch_fault
);

    localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT - 1);

    fetch_state_e state;
    logic [7:0]   timer;
    logic         fetch_req;
    logic [31:0]  fetch_addr;
    logic [31:0]  next_pc;

    mc_next_pc u_next_pc (
        .pc_src      (pc_src),
        .pc_plus4    (pc_plus4),
        .ext_imm     (ext_imm),
        .rs_data     (rs_data),
        .instr_index (ir[25:0]),
        .next_pc     (next_pc)
    );

    assign pc_plus4  = pc + 32'd4;
    assign opcode    = ir[31:26];
    assign rs        = ir[25:21];
    assign rt        = ir[20:16];
    assign rd        = ir[15:11];
    assign sa        = ir[10:6];
    assign imm16     = ir[15:0];
    assign imem.req  = fetch_req;
    assign imem.addr = fetch_addr;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= StIdle;
            timer       <= 8'd0;
            fetch_req   <= 1'b0;
            fetch_addr  <= 32'd0;
            pc          <= RESET_PC;
            ir          <= 32'd0;
            fetch_busy  <= 1'b0;
            ir_valid    <= 1'b0;
            halted      <= 1'b0;
            fetch_fault <= 1'b0;
        end else begin
            ir_valid <= 1'b0;

            // PC updates are independent of the fetch; the in-flight address is latched.
            if (pc_wre && !halted) begin
                pc <= next_pc;
            end

            case (state)
                StIdle: begin
                    if (ir_wre && !halted) begin
                        fetch_addr <= {pc[31:2], 2'b00};
                        timer      <= 8'd0;
                        fetch_req  <= 1'b1;
                        fetch_busy <= 1'b1;
                        state      <= StReq;
                    end
                end
                StReq: begin
                    timer <= timer + 8'd1;
                    if (imem.ack) begin
                        ir         <= imem.rdata;
                        fetch_req  <= 1'b0;
                        fetch_busy <= 1'b0;
                        ir_valid   <= 1'b1;
                        state      <= StDone;
                    end else if (timer == TIMER_LAST) begin
                        // Timeout injects HALT so the CPU stops cleanly.
                        ir          <= HALT_INSN;
                        fetch_fault <= 1'b1;
                        fetch_req   <= 1'b0;
                        fetch_busy  <= 1'b0;
                        ir_valid    <= 1'b1;
                        state       <= StDone;
                    end
                end
                StDone: begin
                    if (ir[31:26] == OP_HALT) begin
                        halted <= 1'b1;
                    end
                    state <= StIdle;
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mc_fetch_unit.sv
// Self-checking bench for mc_fetch_unit: directed scenarios plus randomized
// PC writes and fetches compared against a spec-level reference model.
module tb_mc_fetch_unit;

    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam int          TIMEOUT   = 16;
    localparam logic [31:0] HALT_WORD = 32'hFC00_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        pc_wre;
    logic        ir_wre;
    logic [1:0]  pc_src;
    logic [31:0] ext_imm;
    logic [31:0] rs_data;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] ir;
    logic [5:0]  opcode;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  sa;
    logic [15:0] imm16;
    logic        fetch_busy;
    logic        ir_valid;
    logic        halted;
    logic        fetch_fault;

    mc_fetch_unit_if imem ();

    mc_fetch_unit #(
        .RESET_PC (RESET_PC),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .pc_wre      (pc_wre),
        .ir_wre      (ir_wre),
        .pc_src      (pc_src),
        .ext_imm     (ext_imm),
        .rs_data     (rs_data),
        .imem        (imem),
        .pc          (pc),
        .pc_plus4    (pc_plus4),
        .ir          (ir),
        .opcode      (opcode),
        .rs          (rs),
        .rt          (rt),
        .rd          (rd),
        .sa          (sa),
        .imm16       (imm16),
        .fetch_busy  (fetch_busy),
        .ir_valid    (ir_valid),
        .halted      (halted),
        .fetch_fault (fetch_fault)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [31:0] m_pc;
    logic [31:0] m_ir;
    logic        m_halted;
    logic        m_fault;

    function automatic logic [31:0] ref_next_pc(input logic [1:0] src, input logic [31:0] cur_pc,
                                                input logic [31:0] cur_ir, input logic [31:0] imm,
                                                input logic [31:0] rsv);
        logic [31:0] link;
        link = cur_pc + 32'd4;
        case (src)
            2'd0:    return link;
            2'd1:    return link + imm * 32'd4;
            2'd2:    return rsv - (rsv % 32'd4);
            default: return (link & 32'hF000_0000) | ((cur_ir % 32'h0400_0000) * 32'd4);
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check_state(input string tag);
        check({tag, "_pc"}, pc, m_pc);
        check({tag, "_pc_plus4"}, pc_plus4, m_pc + 32'd4);
        check({tag, "_ir"}, ir, m_ir);
        check({tag, "_opcode"}, 32'(opcode), m_ir / 32'h0400_0000);
        check({tag, "_rs"}, 32'(rs), (m_ir / 32'h0020_0000) % 32);
        check({tag, "_rt"}, 32'(rt), (m_ir / 32'h0001_0000) % 32);
        check({tag, "_rd"}, 32'(rd), (m_ir / 32'h0000_0800) % 32);
        check({tag, "_sa"}, 32'(sa), (m_ir / 32'h0000_0040) % 32);
        check({tag, "_imm16"}, 32'(imm16), m_ir % 32'h0001_0000);
        check({tag, "_fault"}, 32'(fetch_fault), 32'(m_fault));
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset    = 1'b0;
        m_pc     = RESET_PC;
        m_ir     = 32'd0;
        m_halted = 1'b0;
        m_fault  = 1'b0;
    endtask

    task automatic pc_write(input logic [1:0] src, input logic [31:0] imm, input logic [31:0] rsv);
        pc_wre  = 1'b1;
        pc_src  = src;
        ext_imm = imm;
        rs_data = rsv;
        tick();
        pc_wre = 1'b0;
        if (!m_halted) m_pc = ref_next_pc(src, m_pc, m_ir, imm, rsv);
        check("pc_wre", pc, m_pc);
    endtask

    // delay = idle req cycles before ack; delay >= TIMEOUT means never ack.
    task automatic fetch(input logic [31:0] data, input int delay, input bit with_pc,
                         input logic [1:0] src, input logic [31:0] imm, input logic [31:0] rsv,
                         input bit busy_poke);
        logic [31:0] exp_addr;
        bit          acked;
        exp_addr = m_pc - (m_pc % 32'd4);
        acked    = 1'b0;
        ir_wre   = 1'b1;
        if (with_pc) begin
            pc_wre  = 1'b1;
            pc_src  = src;
            ext_imm = imm;
            rs_data = rsv;
        end
        tick();
        ir_wre = 1'b0;
        pc_wre = 1'b0;
        if (with_pc && !m_halted) m_pc = ref_next_pc(src, m_pc, m_ir, imm, rsv);
        if (m_halted) begin
            for (int k = 0; k < 3; k++) begin
                check("halted_no_req", 32'(imem.req), 32'd0);
                tick();
            end
            check("halted_pc", pc, m_pc);
            return;
        end
        for (int k = 0; k < TIMEOUT; k++) begin
            check("req_held", 32'(imem.req), 32'd1);
            check("addr_stable", imem.addr, exp_addr);
            check("busy_in_req", 32'(fetch_busy), 32'd1);
            check("no_valid_in_req", 32'(ir_valid), 32'd0);
            if (busy_poke && k == 0) ir_wre = 1'b1;
            if (k == delay) begin
                imem.ack   = 1'b1;
                imem.rdata = data;
            end
            tick();
            imem.ack   = 1'b0;
            imem.rdata = $urandom;
            ir_wre     = 1'b0;
            if (k == delay) begin
                acked = 1'b1;
                break;
            end
        end
        if (acked) begin
            m_ir = data;
        end else begin
            m_ir    = HALT_WORD;
            m_fault = 1'b1;
        end
        check("done_valid", 32'(ir_valid), 32'd1);
        check("done_busy", 32'(fetch_busy), 32'd0);
        check("done_req", 32'(imem.req), 32'd0);
        check("done_halted", 32'(halted), 32'(m_halted));
        check_state("done");
        tick();
        m_halted = m_halted || (m_ir / 32'h0400_0000 == 32'h3F);
        check("pulse_end", 32'(ir_valid), 32'd0);
        check("no_extra_req", 32'(imem.req), 32'd0);
        check("halted", 32'(halted), 32'(m_halted));
    endtask

    initial begin
        logic [31:0] d;
        reset      = 1'b1;
        pc_wre     = 1'b0;
        ir_wre     = 1'b0;
        pc_src     = 2'd0;
        ext_imm    = 32'd0;
        rs_data    = 32'd0;
        imem.ack   = 1'b0;
        imem.rdata = 32'd0;
        tick();
        do_reset();

        // Reset state
        check("rst_req", 32'(imem.req), 32'd0);
        check("rst_busy", 32'(fetch_busy), 32'd0);
        check("rst_valid", 32'(ir_valid), 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        check_state("rst");

        // Immediate ack
        fetch(32'h0022_1800, 0, 1'b0, 2'd0, 32'd0, 32'd0, 1'b0);
        check("t1_rd", 32'(rd), 32'd3);
        check("t1_opcode", 32'(opcode), 32'd0);

        // Next-PC selection
        pc_write(2'd2, 32'd0, 32'd8);
        check("t2_pc8", pc, 32'h8);
        pc_write(2'd1, 32'hFFFF_FFFE, 32'd0);
        check("t2_branch", pc, 32'h4);
        fetch(32'hE000_0010, 1, 1'b0, 2'd0, 32'd0, 32'd0, 1'b0);
        pc_write(2'd3, 32'd0, 32'd0);
        check("t2_jump", pc, 32'h40);
        pc_write(2'd2, 32'd0, 32'h103);
        check("t2_jr", pc, 32'h100);

        // Delayed ack with a redundant ir_wre while busy
        fetch(32'h1234_5678, 3, 1'b0, 2'd0, 32'd0, 32'd0, 1'b1);

        // Randomized PC writes and fetches
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 1) == 0) begin
                pc_write(2'($urandom_range(0, 3)), $urandom, $urandom);
            end else begin
                d = $urandom;
                if (d[31:26] == 6'h3F) d[31] = 1'b0;
                fetch(d, $urandom_range(0, 4), 1'($urandom_range(0, 1)),
                      2'($urandom_range(0, 3)), $urandom, $urandom, 1'($urandom_range(0, 1)));
            end
        end

        // HALT fetched: later pc_wre and ir_wre are ignored
        fetch(HALT_WORD, 1, 1'b0, 2'd0, 32'd0, 32'd0, 1'b0);
        check("t4_halted", 32'(halted), 32'd1);
        pc_write(2'd2, 32'd0, 32'h0000_0F00);
        fetch(32'h0000_0000, 0, 1'b1, 2'd0, 32'd0, 32'd0, 1'b0);

        // Fetch timeout
        do_reset();
        fetch(32'h0, TIMEOUT, 1'b0, 2'd0, 32'd0, 32'd0, 1'b0);
        check("t5_fault", 32'(fetch_fault), 32'd1);
        check("t5_halted", 32'(halted), 32'd1);
        check("t5_ir", ir, HALT_WORD);

        // Reset in the 2nd req cycle, then a late ack
        do_reset();
        check("t6_fault_clr", 32'(fetch_fault), 32'd0);
        pc_write(2'd2, 32'd0, 32'h0000_0200);
        ir_wre = 1'b1;
        tick();
        ir_wre = 1'b0;
        check("t6_req1", 32'(imem.req), 32'd1);
        tick();
        check("t6_req2", 32'(imem.req), 32'd1);
        reset = 1'b1;
        tick();
        reset    = 1'b0;
        m_pc     = RESET_PC;
        m_ir     = 32'd0;
        m_halted = 1'b0;
        m_fault  = 1'b0;
        check("t6_req_drop", 32'(imem.req), 32'd0);
        check("t6_busy", 32'(fetch_busy), 32'd0);
        check_state("t6_rst");
        imem.ack   = 1'b1;
        imem.rdata = 32'hDEAD_BEEF;
        tick();
        imem.ack = 1'b0;
        check("t6_late_ack_valid", 32'(ir_valid), 32'd0);
        check_state("t6_late_ack");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
